// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch->queue->decode handshake bundle (push side, pop side, flush, occupancy)
interface fetch_queue_if #(parameter int AW = 2);
  logic          in_valid;
  logic [31:0]   in_ir;
  logic [31:0]   in_pc4;
  logic          in_ready;
  logic          out_valid;
  logic [31:0]   out_ir;
  logic [31:0]   out_pc4;
  logic          out_ready;
  logic          flush;
  logic [AW:0]   count;
  modport master (
    output in_valid, in_ir, in_pc4, out_ready, flush,
    input  in_ready, out_valid, out_ir, out_pc4, count
  );
  modport slave (
    input  in_valid, in_ir, in_pc4, out_ready, flush,
    output in_ready, out_valid, out_ir, out_pc4, count
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {instr, pc+4} pairs between fetch and decode, flushed on redirect
// Ports: clk, reset (async, active-high); q (fetch_queue_if.slave): in_valid/in_ir/in_pc4/in_ready push side,
//   out_valid/out_ir/out_pc4/out_ready pop side, flush discards all entries, count = occupancy.
// Option: define FETCH_Q_BYPASS_EN to route input straight to output when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic         clk,
  input logic         reset,
  fetch_queue_if.slave q
);
  logic [63:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty, bypass, push, pop;
  always_comb begin
    empty       = cnt_q == '0;
`ifdef FETCH_Q_BYPASS_EN
    bypass      = empty & q.in_valid & ~q.flush;
`else
    bypass      = 1'b0;
`endif
    q.in_ready  = cnt_q != (AW+1)'(DEPTH);
    // a bypassed entry taken by decode this cycle never enters the array
    push        = q.in_valid & q.in_ready & ~q.flush & ~(bypass & q.out_ready);
    pop         = ~empty & q.out_ready & ~q.flush;
    q.out_valid = ~empty | bypass;
    {q.out_ir, q.out_pc4} = bypass ? {q.in_ir, q.in_pc4} : empty ? 64'h0 : mem_q[rp_q];
    q.count     = cnt_q;
    wp_d        = q.flush ? '0 : wp_q + AW'(push);
    rp_d        = q.flush ? '0 : rp_q + AW'(pop);
    cnt_d       = q.flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= {q.in_ir, q.in_pc4};
  end
endmodule
